seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit multiplexed scanner for the board's 7-segment display, sitting directly upstream of the hex encoder. It holds a 16-bit display word and time-multiplexes the four digits. Each slot presents one 4-bit nibble to the encoder's `bin` input and drives the matching active-low anode and decimal point. A blanking guard interval between digit slots suppresses ghosting.

## Interface
- `DIV`, 100000: clock cycles each digit is lit, with a legal range of 1..2^20. At 100 MHz this gives 1 ms per digit.
- `GUARD`, 1000: clock cycles with all anodes off between digit slots, with a legal range of 0..2^16. A value of 0 disables the guard.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: scan enable. When low, the display is dark and scanning is frozen.
- `load` input, 1 bit: single-cycle strobe that captures `value` and `dp_in`.
- `value` input, 16 bits: display word. Digit d is `value[4d+3:4d]`, and digit 0 is the rightmost.
- `dp_in` input, 4 bits: decimal point request per digit, 1 = lit.
- `nib` output, 4 bits: nibble for the hex encoder's `bin` input.
- `an` output, 4 bits: active-low anode enables. `an[d]` = 0 lights digit d.
- `dp` output, 1 bit: active-low decimal point for the lit digit. Downstream replaces encoder bit 7 with this signal.

## Operation
- **Shadow registers.** `sh_val[15:0]` and `sh_dp[3:0]` are written on any edge where `load` = 1. Otherwise they hold.
- **Counters.**
  - `d[1:0]` is the current digit index.
  - `cnt` is a slot counter wide enough for max(DIV, GUARD).
- **State machine.** There are two states, SHOW and GUARD.
  - SHOW: `cnt` counts 0..DIV-1. On the edge with `cnt` = DIV-1:
    - if GUARD > 0, go to GUARD with `cnt` = 0;
    - otherwise stay in SHOW with `d` = d+1 and `cnt` = 0.
  - GUARD: `cnt` counts 0..GUARD-1. On the edge with `cnt` = GUARD-1, go to SHOW with `d` = d+1 and `cnt` = 0.
  - `d` wraps from 3 to 0, giving the order 0,1,2,3,0,…
- **Registered outputs.** `an`, `nib` and `dp` are registers updated on the same edge as the state, `d` and `cnt`. Their values follow from the post-edge state.
  - SHOW, digit d:
    - `an` = ~(4'b0001 << d);
    - `nib` = sh_val nibble d;
    - `dp` = ~sh_dp[d].
  - GUARD:
    - `an` = 4'hF;
    - `dp` = 1;
    - `nib` = nibble of the upcoming digit d+1, so the encoder settles before the anode turns on.
- **Nibble refresh.** `nib` and `dp` are re-sampled from the shadow registers every cycle. A load during a SHOW slot takes effect mid-slot.
- **Enable low.**
  - State, `d` and `cnt` hold.
  - `an` is forced to 4'hF and `dp` to 1. `nib` keeps tracking its normal selection.
  - `load` still captures.
  - When `en` returns high, the scan resumes exactly where it froze.
- **Reset.** Reset is asynchronous and applies immediately, including mid-slot. It sets:
  - state = GUARD, `d` = 3, `cnt` = 0;
  - `sh_val` = 0, `sh_dp` = 0;
  - `an` = 4'hF, `nib` = 0, `dp` = 1.

  As a result, digit 0 is the first digit lit after reset release.

## Timing
- **Slot sequence.** With `en` = 1, each slot is DIV cycles lit followed by GUARD cycles dark. The full scan period is 4·(DIV+GUARD) cycles.
- **First lit digit after reset.** The first edge after `rst_n` rises is cycle 1.
  - With GUARD > 0, `an` goes to 4'b1110 at the edge ending cycle GUARD.
  - With GUARD = 0, reset exits GUARD on the first edge with `cnt` = 0.
- **Load latency.** For a load sampled at edge k, the shadow registers update at edge k and `nib`/`dp` reflect the new data at edge k+1.
- **Simultaneous events.**
  - A `load` on the slot-boundary edge: the new digit shows the old nibble for one cycle, then the new nibble.
  - An `en` falling edge coinciding with a slot boundary: the transition does not occur.

## Configuration
- **`SEG_SCAN_LZ_BLANK_EN` defined:** leading-zero blanking is compiled in.
  - In SHOW, digit d's anode stays high (1) when d > 0 and every nibble of sh_val from d up to 3 is 0.
  - Digit 0 is always lit.
  - Slot timing is unchanged; the blanked digit's slot simply stays dark.
  - A digit whose `sh_dp` bit is set is never blanked.
- **Not defined:** all four digits are always lit in SHOW.

## Test plan
- **Reset and scan order.** DIV=4, GUARD=2, release reset, `en`=1.
  - Required: `an` = F for 2 cycles, then 1110×4, F×2, 1101×4, F×2, 1011×4, F×2, 0111×4.
  - The 24-cycle period must repeat.
- **Load and nibble order.** Load value=16'h12AF, dp_in=4'b0100.
  - Required: `nib` in successive SHOW slots is F, A, 2, 1.
  - `dp` = 0 only during digit 2's slot.
  - During each GUARD, `nib` already shows the next digit's nibble.
- **No guard.** DIV=3, GUARD=0.
  - Required: `an` is never 4'hF after the first slot.
  - Each digit is lit for exactly 3 cycles.
- **Enable freeze.** Drop `en` 2 cycles into digit 1's SHOW slot, hold it low for 10 cycles, then raise it.
  - Required: `an` = F while `en` is low.
  - Digit 1 then lights for its remaining 2 cycles before GUARD.
- **Reset mid-slot.** Assert `rst_n` low asynchronously, between clock edges, during digit 2's slot.
  - Required: `an` = F, `nib` = 0 and `dp` = 1 immediately.
  - After release, the scan restarts at digit 0.
  - All shadow data reads back as 0.
- **Leading-zero blanking.** Macro defined, value=16'h0042.
  - Required: digits 2 and 3 stay dark in their slots.
  - value=0 with dp_in=4'b1000 lights only digit 0 and digit 3, with `dp` = 0 on digit 3.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with a blanked guard interval between digit slots.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned GUARD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned MaxCnt = (DIV > GUARD) ? DIV : GUARD;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CntW-1:0] DivLast   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] GuardLast = (GUARD > 0) ? CntW'(GUARD - 1) : '0;

  typedef enum logic {StShow, StGuard} state_e;

  state_e          st_q, st_d;
  logic [1:0]      d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     sh_val_q;
  logic [3:0]      sh_dp_q;
  logic [3:0]      an_q, an_d;
  logic [3:0]      nib_q, nib_d;
  logic            dp_q, dp_d;
  logic [1:0]      sel;
  logic            show;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [3:0] blank;
  logic       z3, z2, z1;

  always_comb begin
    z3    = (sh_val_q[15:12] == 4'h0);
    z2    = z3 && (sh_val_q[11:8] == 4'h0);
    z1    = z2 && (sh_val_q[7:4] == 4'h0);
    blank = {z3 && !sh_dp_q[3], z2 && !sh_dp_q[2], z1 && !sh_dp_q[1], 1'b0};
  end
`endif

  // Slot sequencing; everything holds while en is low.
  always_comb begin
    st_d  = st_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (en) begin
      unique case (st_q)
        StShow: begin
          if (cnt_q == DivLast) begin
            cnt_d = '0;
            if (GUARD > 0) st_d = StGuard;
            else           d_d  = d_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StGuard: begin
          if ((GUARD == 0) || (cnt_q == GuardLast)) begin
            st_d  = StShow;
            d_d   = d_q + 2'd1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: st_d = StGuard;
      endcase
    end
  end

  // Outputs follow the post-edge state but sample the pre-edge shadow registers.
  always_comb begin
    sel   = (st_d == StGuard) ? d_d + 2'd1 : d_d;
    show  = en && (st_d == StShow);
    nib_d = sh_val_q[{sel, 2'b00} +: 4];
    an_d  = show ? ~(4'b0001 << d_d) : 4'hF;
    dp_d  = show ? ~sh_dp_q[d_d] : 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (show && blank[d_d]) an_d = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= StGuard;
      d_q      <= 2'd3;
      cnt_q    <= '0;
      sh_val_q <= 16'h0000;
      sh_dp_q  <= 4'h0;
      an_q     <= 4'hF;
      nib_q    <= 4'h0;
      dp_q     <= 1'b1;
    end else begin
      st_q  <= st_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      an_q  <= an_d;
      nib_q <= nib_d;
      dp_q  <= dp_d;
      if (load) begin
        sh_val_q <= value;
        sh_dp_q  <= dp_in;
      end
    end
  end

  assign an  = an_q;
  assign nib = nib_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: stimulus queues hand-computed per-cycle outputs, a monitor
// compares them on the falling edge. Blanking checks apply when SEG_SCAN_LZ_BLANK_EN is defined.
module tb_seg_scan;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit Lz = 1'b1;
`else
  localparam bit Lz = 1'b0;
`endif

  typedef struct {
    bit          sel;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, load, dp_o;
  logic [15:0] value;
  logic [3:0]  dp_in, nib_o, an_o;

  logic        rst_nb, load_b, dp_b;
  logic        en_b = 1'b1;
  logic [15:0] value_b;
  logic [3:0]  dp_in_b = 4'h0;
  logic [3:0]  nib_b, an_b;

  seg_scan #(.DIV(4), .GUARD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .nib(nib_o), .an(an_o), .dp(dp_o)
  );

  seg_scan #(.DIV(3), .GUARD(0)) u_dut_ng (
    .clk(clk), .rst_n(rst_nb), .en(en_b), .load(load_b), .value(value_b), .dp_in(dp_in_b),
    .nib(nib_b), .an(an_b), .dp(dp_b)
  );

  task automatic cmp(input exp_t e, input logic [3:0] a_an, input logic [3:0] a_nib,
                     input logic a_dp);
    n_checks++;
    if (a_an !== e.an || a_nib !== e.nib || a_dp !== e.dp) begin
      n_errors++;
      $display("FAIL %s @%0t: got an=%b nib=%h dp=%b, required an=%b nib=%h dp=%b",
               e.name, $time, a_an, a_nib, a_dp, e.an, e.nib, e.dp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel) cmp(e, an_b, nib_b, dp_b);
      else       cmp(e, an_o, nib_o, dp_o);
    end
  end

  // Queue one cycle's expected outputs, then let that cycle run.
  task automatic step(input bit s, input logic [3:0] a, input logic [3:0] n, input logic p,
                      input string nm);
    exp_t e;
    e.sel = s; e.an = a; e.nib = n; e.dp = p; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rep(input bit s, input logic [3:0] a, input logic [3:0] n, input logic p,
                     input int cnt, input string nm);
    for (int i = 0; i < cnt; i++) step(s, a, n, p, nm);
  endtask

  task automatic now_chk(input string nm);
    exp_t e;
    e.sel = 1'b0; e.an = 4'hF; e.nib = 4'h0; e.dp = 1'b1; e.name = nm;
    cmp(e, an_o, nib_o, dp_o);
  endtask

  logic [3:0] san [4];

  initial begin
    // Anode pattern per digit with an all-zero display word.
    san[0] = 4'b1110;
    san[1] = Lz ? 4'hF : 4'b1101;
    san[2] = Lz ? 4'hF : 4'b1011;
    san[3] = Lz ? 4'hF : 4'b0111;

    rst_n = 1'b0; en = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    rst_nb = 1'b0; load_b = 1'b0; value_b = 16'h8000;
    @(negedge clk);
    now_chk("reset_state");

    // No-guard instance: first edge leaves reset straight into digit 0.
    #2 rst_nb = 1'b1; load_b = 1'b1;
    step(1'b1, 4'b1110, 4'h0, 1'b1, "ng_d0");
    load_b = 1'b0;
    rep(1'b1, 4'b1110, 4'h0, 1'b1, 2, "ng_d0");
    rep(1'b1, 4'b1101, 4'h0, 1'b1, 3, "ng_d1");
    rep(1'b1, 4'b1011, 4'h0, 1'b1, 3, "ng_d2");
    rep(1'b1, 4'b0111, 4'h8, 1'b1, 3, "ng_d3");
    rep(1'b1, 4'b1110, 4'h0, 1'b1, 3, "ng_d0_again");
    rep(1'b1, 4'b1101, 4'h0, 1'b1, 3, "ng_d1_again");

    // Reset release and scan order, one full period plus the start of the next.
    now_chk("reset_hold");
    #2 rst_n = 1'b1;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t1_first_guard");
    for (int r = 0; r < 5; r++) begin
      rep(1'b0, san[r % 4], 4'h0, 1'b1, 4, "t1_show");
      if (r < 4) rep(1'b0, 4'hF, 4'h0, 1'b1, 2, "t1_guard");
    end

    // Load and nibble order from a fresh reset.
    #1 rst_n = 1'b0;
    #1 now_chk("t2_async_rst");
    #1 rst_n = 1'b1; load = 1'b1; value = 16'h12AF; dp_in = 4'b0100;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t2_load_edge");
    load = 1'b0;
    rep(1'b0, 4'b1110, 4'hF, 1'b1, 4, "t2_d0");
    rep(1'b0, 4'hF,    4'hA, 1'b1, 2, "t2_g0");
    rep(1'b0, 4'b1101, 4'hA, 1'b1, 4, "t2_d1");
    rep(1'b0, 4'hF,    4'h2, 1'b1, 2, "t2_g1");
    rep(1'b0, 4'b1011, 4'h2, 1'b0, 4, "t2_d2");
    rep(1'b0, 4'hF,    4'h1, 1'b1, 2, "t2_g2");
    rep(1'b0, 4'b0111, 4'h1, 1'b1, 4, "t2_d3");
    rep(1'b0, 4'hF,    4'hF, 1'b1, 2, "t2_g3");

    // Enable freeze two cycles into digit 1.
    rep(1'b0, 4'b1110, 4'hF, 1'b1, 4, "t4_d0");
    rep(1'b0, 4'hF,    4'hA, 1'b1, 2, "t4_g0");
    rep(1'b0, 4'b1101, 4'hA, 1'b1, 2, "t4_d1_pre");
    en = 1'b0;
    rep(1'b0, 4'hF,    4'hA, 1'b1, 10, "t4_frozen");
    en = 1'b1;
    rep(1'b0, 4'b1101, 4'hA, 1'b1, 2, "t4_d1_resume");
    rep(1'b0, 4'hF,    4'h2, 1'b1, 2, "t4_g1");
    rep(1'b0, 4'b1011, 4'h2, 1'b0, 2, "t4_d2");

    // Reset in the middle of digit 2's slot.
    #2 rst_n = 1'b0;
    #1 now_chk("t5_async_rst");
    rep(1'b0, 4'hF, 4'h0, 1'b1, 2, "t5_in_reset");
    #2 rst_n = 1'b1;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t5_first_guard");
    rep(1'b0, san[0], 4'h0, 1'b1, 4, "t5_d0_cleared");
    rep(1'b0, 4'hF,   4'h0, 1'b1, 2, "t5_g0");
    rep(1'b0, san[1], 4'h0, 1'b1, 4, "t5_d1_cleared");
    rep(1'b0, 4'hF,   4'h0, 1'b1, 2, "t5_g1");
    rep(1'b0, san[2], 4'h0, 1'b1, 4, "t5_d2_cleared");

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Leading-zero blanking with 0042, then zero with a decimal point on digit 3.
    load = 1'b1; value = 16'h0042; dp_in = 4'b0000;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t6_load_a");
    load = 1'b0;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t6_g2");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 4, "t6_d3_blank");
    rep(1'b0, 4'hF,    4'h2, 1'b1, 2, "t6_g3");
    rep(1'b0, 4'b1110, 4'h2, 1'b1, 4, "t6_d0");
    rep(1'b0, 4'hF,    4'h4, 1'b1, 2, "t6_g0");
    rep(1'b0, 4'b1101, 4'h4, 1'b1, 4, "t6_d1");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 2, "t6_g1");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 4, "t6_d2_blank");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 2, "t6_g2b");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 4, "t6_d3_blank_b");
    load = 1'b1; value = 16'h0000; dp_in = 4'b1000;
    step(1'b0, 4'hF, 4'h2, 1'b1, "t6_load_b");
    load = 1'b0;
    step(1'b0, 4'hF, 4'h0, 1'b1, "t6_g3b");
    rep(1'b0, 4'b1110, 4'h0, 1'b1, 4, "t6z_d0");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 2, "t6z_g0");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 4, "t6z_d1_blank");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 2, "t6z_g1");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 4, "t6z_d2_blank");
    rep(1'b0, 4'hF,    4'h0, 1'b1, 2, "t6z_g2");
    rep(1'b0, 4'b0111, 4'h0, 1'b0, 4, "t6z_d3_dp");
`endif

    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
